// File: rtl/regfile_writeback_pkg.sv
// Shared types, sizes and load-formatting helpers for the register-file
// writeback stage.
package regfile_writeback_pkg;

   localparam int XLEN     = 64;
   localparam int RD_W     = 5;
   localparam int LQ_DEPTH = 2;
   localparam int LQ_CNT_W = $clog2(LQ_DEPTH + 1);

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LD  = 3'b011,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101,
      F3_LWU = 3'b110,
      F3_ILL = 3'b111
   } ld_funct3_e;

   // One pending-load slot. A killed entry keeps its slot but writes nothing.
   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] data;
   } lq_entry_t;

   // True when the load cannot be performed: bad encoding or misaligned offset.
   function automatic logic load_illegal(input logic [2:0] funct3,
                                         input logic [2:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (ld_funct3_e'(funct3))
         F3_LH, F3_LHU: bad = addr_lo[0];
         F3_LW, F3_LWU: bad = |addr_lo[1:0];
         F3_LD:         bad = |addr_lo;
         F3_ILL:        bad = 1'b1;
         default:       bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Shift the addressed element down to bit 0, then sign- or zero-extend.
   function automatic logic [XLEN-1:0] load_format(input logic [2:0]      funct3,
                                                   input logic [2:0]      addr_lo,
                                                   input logic [XLEN-1:0] data);
      logic [XLEN-1:0] sh;
      logic [XLEN-1:0] res;
      sh = data >> {addr_lo, 3'b000};
      case (ld_funct3_e'(funct3))
         F3_LB:   res = {{(XLEN-8){sh[7]}},   sh[7:0]};
         F3_LH:   res = {{(XLEN-16){sh[15]}}, sh[15:0]};
         F3_LW:   res = {{(XLEN-32){sh[31]}}, sh[31:0]};
         F3_LBU:  res = {{(XLEN-8){1'b0}},    sh[7:0]};
         F3_LHU:  res = {{(XLEN-16){1'b0}},   sh[15:0]};
         F3_LWU:  res = {{(XLEN-32){1'b0}},   sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// ALU result, load-return handshake and register-file write port of the
// writeback stage. The slave side is the writeback stage itself.
interface regfile_writeback_if;
   import regfile_writeback_pkg::*;

   logic                alu_valid;
   logic [RD_W-1:0]     alu_rd;
   logic [XLEN-1:0]     alu_result;

   logic                ld_valid;
   logic                ld_ready;
   logic [RD_W-1:0]     ld_rd;
   logic [2:0]          ld_funct3;
   logic [2:0]          ld_addr_lo;
   logic [XLEN-1:0]     ld_data;

   logic                write_en;
   logic [RD_W-1:0]     write_register;
   logic [XLEN-1:0]     write_data;
   logic                ld_err;
   logic [LQ_CNT_W-1:0] lq_count;

   modport master (
      output alu_valid, alu_rd, alu_result,
      output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_data,
      input  ld_ready,
      input  write_en, write_register, write_data, ld_err, lq_count
   );

   modport slave (
      input  alu_valid, alu_rd, alu_result,
      input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_data,
      output ld_ready,
      output write_en, write_register, write_data, ld_err, lq_count
   );

endinterface

// File: rtl/regfile_writeback_lq.sv
// Pending-load FIFO. Entries whose rd matches a younger ALU write can be
// invalidated in place; they still drain in order but are never written.
module wb_load_queue
   import regfile_writeback_pkg::*;
#(
   parameter  int DEPTH = LQ_DEPTH,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  lq_entry_t        push_entry,
   input  logic             pop,
   input  logic             kill_en,
   input  logic [RD_W-1:0]  kill_rd,
   output lq_entry_t        head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   lq_entry_t        mem_q [DEPTH];
   lq_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Next-state: kill matching entries, then retire the head, then append.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (kill_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].rd == kill_rd) begin
               mem_d[i].valid = 1'b0;
            end
         end
      end
      if (pop) begin
         mem_d[rd_ptr_q].valid = 1'b0;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // A push into the slot being popped (full queue) must win, so it comes last.
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Queue storage and pointers; reset leaves every slot invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: one registered register-file write per cycle, chosen from
// the ALU result, the oldest queued load, or a load bypassing an empty queue.
module regfile_writeback
   import regfile_writeback_pkg::*;
(
   input logic                clk,
   input logic                rst,
   regfile_writeback_if.slave wb
);

   lq_entry_t           lq_head;
   lq_entry_t           push_entry;
   logic                lq_push, lq_pop, lq_full, lq_empty;
   logic [LQ_CNT_W-1:0] lq_count_w;

   logic                ld_ready, ld_fire, ld_bad, ld_take, ld_killed, ld_bypass;
   logic [XLEN-1:0]     ld_fmt;

   logic                sel_en;
   logic [RD_W-1:0]     sel_rd;
   logic [XLEN-1:0]     sel_data;

   logic                write_en_q, write_en_d;
   logic [RD_W-1:0]     write_register_q, write_register_d;
   logic [XLEN-1:0]     write_data_q, write_data_d;
   logic                ld_err_q, ld_err_d;

   // Load acceptance: handshake, legality, and where an accepted load goes.
   always_comb begin
      // A full queue can still accept when its head drains, i.e. no ALU this cycle.
      ld_ready   = ~rst & (~lq_full | ~wb.alu_valid);
      ld_fire    = wb.ld_valid & ld_ready;
      ld_bad     = load_illegal(wb.ld_funct3, wb.ld_addr_lo);
      ld_fmt     = load_format(wb.ld_funct3, wb.ld_addr_lo, wb.ld_data);
      ld_take    = ld_fire & ~ld_bad;
      // The load is older than the same-cycle ALU result, so it is overwritten.
      ld_killed  = ld_take & wb.alu_valid & (wb.ld_rd == wb.alu_rd);
      ld_bypass  = ld_take & ~wb.alu_valid & lq_empty;
      lq_push    = ld_take & ~ld_killed & ~ld_bypass;
      lq_pop     = ~wb.alu_valid & ~lq_empty;
      push_entry = '{valid: 1'b1, rd: wb.ld_rd, data: ld_fmt};
   end

   // Write-port arbitration (ALU, then queue head, then bypass) and x0 suppression.
   always_comb begin
      sel_en   = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      if (wb.alu_valid) begin
         sel_en   = 1'b1;
         sel_rd   = wb.alu_rd;
         sel_data = wb.alu_result;
      end else if (!lq_empty) begin
         sel_en   = lq_head.valid;
         sel_rd   = lq_head.rd;
         sel_data = lq_head.data;
      end else if (ld_bypass) begin
         sel_en   = 1'b1;
         sel_rd   = wb.ld_rd;
         sel_data = ld_fmt;
      end
      write_en_d       = sel_en & (sel_rd != '0);
      write_register_d = write_en_d ? sel_rd   : '0;
      write_data_d     = write_en_d ? sel_data : '0;
      ld_err_d         = ld_fire & ld_bad;
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_en_q       <= 1'b0;
         write_register_q <= '0;
         write_data_q     <= '0;
         ld_err_q         <= 1'b0;
      end else begin
         write_en_q       <= write_en_d;
         write_register_q <= write_register_d;
         write_data_q     <= write_data_d;
         ld_err_q         <= ld_err_d;
      end
   end

   wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
      .clk        (clk),
      .rst        (rst),
      .push       (lq_push),
      .push_entry (push_entry),
      .pop        (lq_pop),
      .kill_en    (wb.alu_valid),
      .kill_rd    (wb.alu_rd),
      .head       (lq_head),
      .count      (lq_count_w),
      .full       (lq_full),
      .empty      (lq_empty)
   );

   assign wb.ld_ready       = ld_ready;
   assign wb.write_en       = write_en_q;
   assign wb.write_register = write_register_q;
   assign wb.write_data     = write_data_q;
   assign wb.ld_err         = ld_err_q;
   assign wb.lq_count       = lq_count_w;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: a queue-level reference model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_regfile_writeback;
   import regfile_writeback_pkg::*;

   logic clk = 1'b0;
   logic rst;

   regfile_writeback_if wb();

   regfile_writeback dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   initial forever #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_on  = 1'b0;

   typedef struct {
      logic        v;
      logic [4:0]  rd;
      logic [63:0] d;
   } ment_t;

   ment_t mq[$];

   logic        exp_ready, exp_en, exp_err;
   logic [4:0]  exp_rd;
   logic [63:0] exp_data;
   logic [1:0]  exp_cnt;
   logic        nxt_en, nxt_err;
   logic [4:0]  nxt_rd;
   logic [63:0] nxt_data;
   logic [1:0]  nxt_cnt;
   logic        ready_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic int m_bytes(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic m_bad(input logic [2:0] f3, input logic [2:0] off);
      return (f3 == 3'b111) || ((int'(off) % m_bytes(f3)) != 0);
   endfunction

   function automatic logic [63:0] m_format(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] d);
      int          nb;
      logic [63:0] v;
      logic [63:0] mask;
      nb = m_bytes(f3);
      v  = d >> (8 * int'(off));
      if (nb == 8) return v;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v    = v & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      exp_ready = 1'b0;
      exp_en    = 1'b0;
      exp_rd    = '0;
      exp_data  = '0;
      exp_err   = 1'b0;
      exp_cnt   = '0;
   endtask

   // Decide this cycle's outcome from the current inputs and the model queue.
   task automatic model_eval();
      logic        fire, bad, good;
      logic [63:0] fmt;
      ment_t       e;
      exp_ready = !rst && (mq.size() < 2 || !wb.alu_valid);
      fire      = wb.ld_valid && exp_ready;
      bad       = m_bad(wb.ld_funct3, wb.ld_addr_lo);
      good      = fire && !bad;
      fmt       = m_format(wb.ld_funct3, wb.ld_addr_lo, wb.ld_data);
      nxt_err   = fire && bad;
      nxt_en    = 1'b0;
      nxt_rd    = '0;
      nxt_data  = '0;
      if (wb.alu_valid) begin
         foreach (mq[i]) if (mq[i].rd == wb.alu_rd) mq[i].v = 1'b0;
         nxt_en   = (wb.alu_rd != 0);
         nxt_rd   = wb.alu_rd;
         nxt_data = wb.alu_result;
         if (good && wb.ld_rd != wb.alu_rd) mq.push_back('{1'b1, wb.ld_rd, fmt});
      end else if (mq.size() > 0) begin
         e        = mq.pop_front();
         nxt_en   = e.v && (e.rd != 0);
         nxt_rd   = e.rd;
         nxt_data = e.d;
         if (good) mq.push_back('{1'b1, wb.ld_rd, fmt});
      end else if (good) begin
         nxt_en   = (wb.ld_rd != 0);
         nxt_rd   = wb.ld_rd;
         nxt_data = fmt;
      end
      nxt_cnt = 2'(mq.size());
   endtask

   task automatic cycle(input logic av, input logic [4:0] ard, input logic [63:0] ares,
                        input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [2:0] off, input logic [63:0] ldat);
      wb.alu_valid  = av;
      wb.alu_rd     = ard;
      wb.alu_result = ares;
      wb.ld_valid   = lv;
      wb.ld_rd      = lrd;
      wb.ld_funct3  = f3;
      wb.ld_addr_lo = off;
      wb.ld_data    = ldat;
      model_eval();
      #1 ready_seen = wb.ld_ready;
      @(posedge clk);
      exp_en   = nxt_en;
      exp_rd   = nxt_rd;
      exp_data = nxt_data;
      exp_err  = nxt_err;
      exp_cnt  = nxt_cnt;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
   endtask

   task automatic zero_inputs();
      wb.alu_valid  = 1'b0;
      wb.alu_rd     = '0;
      wb.alu_result = '0;
      wb.ld_valid   = 1'b0;
      wb.ld_rd      = '0;
      wb.ld_funct3  = '0;
      wb.ld_addr_lo = '0;
      wb.ld_data    = '0;
   endtask

   // Compare DUT against the model half a cycle after each active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("ld_ready", 64'(wb.ld_ready), 64'(exp_ready));
         chk("write_en", 64'(wb.write_en), 64'(exp_en));
         if (exp_en) begin
            chk("write_register", 64'(wb.write_register), 64'(exp_rd));
            chk("write_data", wb.write_data, exp_data);
         end
         chk("ld_err", 64'(wb.ld_err), 64'(exp_err));
         chk("lq_count", 64'(wb.lq_count), 64'(exp_cnt));
      end
   end

   localparam logic [63:0] EXT_DATA   = 64'h80FF_0000_0000_0000;
   localparam logic [63:0] SWEEP_DATA = 64'h80FE_7F01_C3A5_5A96;

   initial begin
      rst = 1'b1;
      zero_inputs();
      model_reset();
      @(posedge clk);
      #1 chk_on = 1'b1;
      @(posedge clk);
      #1;
      chk("reset write_en", 64'(wb.write_en), 64'd0);
      chk("reset ld_ready", 64'(wb.ld_ready), 64'd0);
      chk("reset lq_count", 64'(wb.lq_count), 64'd0);
      rst = 1'b0;
      idle(1);
      chk("ld_ready after reset", 64'(ready_seen), 64'd1);

      // ALU only
      cycle(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
      chk("alu write_en", 64'(wb.write_en), 64'd1);
      chk("alu write_register", 64'(wb.write_register), 64'd5);
      chk("alu write_data", wb.write_data, 64'h1234);
      cycle(1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
      chk("alu x0 write_en", 64'(wb.write_en), 64'd0);

      // Load extension
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 3'b000, 3'd7, EXT_DATA);
      chk("LB off7", wb.write_data, 64'hFFFF_FFFF_FFFF_FF80);
      chk("LB rd", 64'(wb.write_register), 64'd3);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 3'b100, 3'd6, EXT_DATA);
      chk("LBU off6", wb.write_data, 64'h0000_0000_0000_00FF);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 3'b010, 3'd4, EXT_DATA);
      chk("LW off4", wb.write_data, 64'hFFFF_FFFF_80FF_0000);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 3'b011, 3'd0, EXT_DATA);
      chk("load x0 write_en", 64'(wb.write_en), 64'd0);

      // Contention: loads queue behind ALU results, drain in order
      cycle(1'b1, 5'd1, 64'h11, 1'b1, 5'd7, 3'b011, 3'd0, 64'h7777);
      cycle(1'b1, 5'd2, 64'h22, 1'b1, 5'd8, 3'b011, 3'd0, 64'h8888);
      chk("lq_count full", 64'(wb.lq_count), 64'd2);
      cycle(1'b1, 5'd3, 64'h33, 1'b1, 5'd9, 3'b011, 3'd0, 64'h9999);
      chk("ld_ready full+alu", 64'(ready_seen), 64'd0);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 3'b011, 3'd0, 64'h9999);
      chk("drain first rd", 64'(wb.write_register), 64'd7);
      chk("drain first data", wb.write_data, 64'h7777);
      idle(1);
      chk("drain second rd", 64'(wb.write_register), 64'd8);
      idle(1);
      chk("drain third rd", 64'(wb.write_register), 64'd9);

      // WAW kill of a queued load
      cycle(1'b1, 5'd1, 64'h1, 1'b1, 5'd9, 3'b011, 3'd0, 64'h5);
      cycle(1'b1, 5'd9, 64'hAA, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
      chk("waw alu rd", 64'(wb.write_register), 64'd9);
      chk("waw alu data", wb.write_data, 64'hAA);
      idle(1);
      chk("killed entry write_en", 64'(wb.write_en), 64'd0);
      chk("killed entry drained", 64'(wb.lq_count), 64'd0);

      // Same-cycle load and ALU to one register: load discarded
      cycle(1'b1, 5'd12, 64'h77, 1'b1, 5'd12, 3'b011, 3'd0, 64'h66);
      idle(2);

      // Misaligned and illegal loads
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 3'b001, 3'd3, EXT_DATA);
      chk("misaligned ld_err", 64'(wb.ld_err), 64'd1);
      chk("misaligned write_en", 64'(wb.write_en), 64'd0);
      chk("misaligned lq_count", 64'(wb.lq_count), 64'd0);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 3'b111, 3'd0, EXT_DATA);
      chk("funct3 111 ld_err", 64'(wb.ld_err), 64'd1);
      idle(1);
      chk("ld_err one cycle", 64'(wb.ld_err), 64'd0);

      // Every funct3/offset combination through the bypass path
      for (int f = 0; f < 8; f++) begin
         for (int o = 0; o < 8; o++) begin
            cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'(1 + ((f * 8 + o) % 31)), 3'(f), 3'(o), SWEEP_DATA);
         end
      end
      idle(1);

      // Reset with two loads pending
      cycle(1'b1, 5'd1, 64'h1, 1'b1, 5'd10, 3'b011, 3'd0, 64'hA);
      cycle(1'b1, 5'd2, 64'h2, 1'b1, 5'd11, 3'b011, 3'd0, 64'hB);
      chk("pre-reset lq_count", 64'(wb.lq_count), 64'd2);
      zero_inputs();
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async reset write_en", 64'(wb.write_en), 64'd0);
      chk("async reset write_register", 64'(wb.write_register), 64'd0);
      chk("async reset write_data", wb.write_data, 64'd0);
      chk("async reset ld_err", 64'(wb.ld_err), 64'd0);
      chk("async reset lq_count", 64'(wb.lq_count), 64'd0);
      chk("async reset ld_ready", 64'(wb.ld_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(1);
      chk("ld_ready after mid reset", 64'(ready_seen), 64'd1);
      chk("no write after reset", 64'(wb.write_en), 64'd0);
      idle(3);

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback stage driving the single write port of the 32×64-bit register file. Merges results from the single-cycle ALU path and the memory-load return path, byte-aligns and sign/zero-extends load data, enforces ordering between the two paths, suppresses writes to x0, and presents one registered write per cycle to the register file.

## Interface
- XLEN, 64, datapath width
- LQ_DEPTH, 2, pending-load queue depth (power of two, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle (no backpressure, always taken)
- alu_rd  in  5  ALU destination register
- alu_result  in  XLEN  ALU result
- ld_valid  in  1  load return valid
- ld_ready  out  1  load return accepted when ld_valid && ld_ready
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110
- ld_addr_lo  in  3  byte offset within doubleword
- ld_data  in  XLEN  raw aligned doubleword from memory
- write_en  out  1  register-file write strobe
- write_register  out  5  register-file write index
- write_data  out  XLEN  register-file write data
- ld_err  out  1  one-cycle pulse: misaligned or illegal-funct3 load dropped
- lq_count  out  2  pending-load queue occupancy

## Operation
- Load formatting at acceptance: select byte/half/word at ld_addr_lo, sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU); LD passes through.
- Misaligned (LH/LHU offset odd; LW/LWU offset not multiple of 4; LD offset ≠ 0) or funct3 = 111: handshake completes, nothing enqueued or written, ld_err pulses next cycle.
- Port arbitration each cycle, priority: ALU > queue head > incoming load (bypass only when queue empty and no ALU).
- Load not written same cycle is enqueued (formatted data + rd) in FIFO order.
- ld_ready = queue not full, or queue full and head drains this cycle (no ALU). Combinational from alu_valid and lq_count.
- Ordering: load returns are older than a same-cycle ALU result. When alu_valid, every queued entry with rd == alu_rd is killed (marked invalid, still drains and occupies a slot but writes nothing); a same-cycle incoming load with ld_rd == alu_rd is accepted and discarded.
- rd == 0 from either source: handshake/slot consumed, write_en stays 0.
- Simultaneous enqueue and dequeue: count unchanged; pointers wrap modulo LQ_DEPTH.

## Timing
- All outputs except ld_ready registered; latency 1 cycle from selection to write_en.
- ALU at cycle N → write_en, write_register=alu_rd, write_data=alu_result at N+1.
- Load accepted at N, queue empty, no ALU → write at N+1; otherwise written in the first ALU-free cycle after all older queue entries.
- Reset (asserted, any cycle): write_en=0, write_register=0, write_data=0, ld_err=0, lq_count=0, queue entries invalid, ld_ready=0 while rst is high; ld_ready=1 from the first cycle after deassertion. Reset mid-queue discards pending loads without writing.

## Structure
- rv_pkg: XLEN, funct3 load encodings, load-format function (align + extend), misalign-check function.
- Sub-module wb_load_queue: LQ_DEPTH FIFO of {valid, rd[4:0], data[XLEN-1:0]} with push/pop, rd-match kill, count, full/empty.
- Top: arbitration, formatting, x0 suppression, output registers.

## Test plan
- ALU only: alu_valid, rd=5, result=0x1234 → write_en=1, write_register=5, write_data=0x1234 next cycle; rd=0 → write_en=0.
- Load extend: ld_data=0x80FF_0000_0000_0000, LB offset 7 → write_data=0xFFFF_FFFF_FFFF_FF80; LBU offset 6 → 0xFF; LW offset 4 → 0xFFFF_FFFF_80FF_0000.
- Contention: ALU valid 3 cycles while loads to x7, x8 arrive → lq_count reaches 2, ld_ready=0 on third load, loads written x7 then x8 after ALU stops.
- WAW kill: load to x9 queued, then ALU rd=9 value 0xAA → only 0xAA written to x9; queued entry drains with write_en=0.
- Misaligned: LH offset 3 → handshake completes, ld_err=1 next cycle, no write, lq_count unchanged.
- Reset mid-operation: queue holding 2 loads, assert rst → all outputs 0 asynchronously, no pending write after deassertion, ld_ready=1 next cycle.
